// File: rtl/prach_hb_dec_ch_if.sv
// Streaming bus of the PRACH half-band decimator: two polyphase inputs with
// sideband and bypass, one decimated output with sideband and overflow flag.
interface prach_hb_dec_ch_if #(
  parameter int DW  = 16,
  parameter int CHW = 8
);
  logic signed [DW-1:0] din_dp1;
  logic signed [DW-1:0] din_dp2;
  logic                 din_dv;
  logic [CHW-1:0]       din_chn;
  logic                 sync_in;
  logic                 bypass;
  logic signed [DW-1:0] dout_dq;
  logic                 dout_dv;
  logic [CHW-1:0]       dout_chn;
  logic                 sync_out;
  logic                 ovf;

  modport master (
    output din_dp1, din_dp2, din_dv, din_chn, sync_in, bypass,
    input  dout_dq, dout_dv, dout_chn, sync_out, ovf
  );

  modport slave (
    input  din_dp1, din_dp2, din_dv, din_chn, sync_in, bypass,
    output dout_dq, dout_dv, dout_chn, sync_out, ovf
  );
endinterface

// File: rtl/prach_hb_dec_ch.sv
// Channel-interleaved half-band decimator stage, 5-cycle pipeline.
// Optional output saturation and sticky ovf flag: define PRACH_HB_DEC_SAT_EN.
module prach_hb_dec_ch #(
  parameter int DW                    = 16,
  parameter int CW                    = 18,
  parameter int NUM_CHANNEL           = 32,
  parameter int NUM_UNIQ_COE          = 2,
  parameter int COE [NUM_UNIQ_COE]    = '{-4249, 37013},
  parameter int CHW                   = 8
) (
  input logic              clk,
  input logic              rst_n,
  prach_hb_dec_ch_if.slave bus
);
  localparam int N   = NUM_UNIQ_COE;
  localparam int L2  = (2*N-1)*NUM_CHANNEL;
  localparam int L1  = (N-1)*NUM_CHANNEL;
  localparam int PW  = DW + 1 + CW;
  localparam int AW  = DW + CW + $clog2(2*N) + 1;
  localparam int LAT = 5;
  localparam logic signed [AW-1:0] RND = {{(AW-CW+1){1'b0}}, 1'b1, {(CW-2){1'b0}}};

  typedef struct packed {
    logic           sync;
    logic           dv;
    logic [CHW-1:0] chn;
  } side_t;

  logic signed [DW-1:0] line2 [1:L2];
  logic signed [DW-1:0] tap_a [N];
  logic signed [DW-1:0] tap_b [N];
  logic signed [DW-1:0] centre;
  logic signed [CW-1:0] coe_w [N];

  // NOTE: delay lines are reset like any other state; the first outputs after
  // reset must see zero history rather than whatever the memory powered up with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= L2; i++) line2[i] <= '0;
    end else if (bus.din_dv) begin
      line2[1] <= bus.din_dp2;
      for (int i = 2; i <= L2; i++) line2[i] <= line2[i-1];
    end
  end

  if (L1 > 0) begin : g_line1
    logic signed [DW-1:0] line1 [1:L1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 1; i <= L1; i++) line1[i] <= '0;
      end else if (bus.din_dv) begin
        line1[1] <= bus.din_dp1;
        for (int i = 2; i <= L1; i++) line1[i] <= line1[i-1];
      end
    end
    assign centre = line1[L1];
  end else begin : g_no_line1
    assign centre = bus.din_dp1;
  end

  // Pair k: delay k*NUM_CHANNEL with delay (2N-1-k)*NUM_CHANNEL; delay 0 is the input.
  for (genvar k = 0; k < N; k++) begin : g_tap
    if (k == 0) begin : g_outer
      assign tap_a[k] = bus.din_dp2;
    end else begin : g_inner
      assign tap_a[k] = line2[k*NUM_CHANNEL];
    end
    assign tap_b[k] = line2[(2*N-1-k)*NUM_CHANNEL];
    assign coe_w[k] = CW'(COE[k]);
  end

  logic signed [DW-1:0] s1_a [N];
  logic signed [DW-1:0] s1_b [N];
  logic signed [DW:0]   s2_pre [N];
  logic signed [PW-1:0] s3_prod [N];
  logic signed [DW-1:0] s1_c, s2_c, s3_c, s4_c;
  logic                 s1_byp, s2_byp, s3_byp, s4_byp;
  logic signed [AW-1:0] s4_acc, acc_sum;
  logic signed [DW-1:0] dq_q, dq_nxt;
  side_t                side_q [1:LAT];

  // NOTE: blocking assignments here build a combinational sum; starting from a
  // full default keeps the process free of inferred latches.
  always_comb begin
    acc_sum = (AW'(s3_c) <<< (CW-2)) + RND;
    for (int k = 0; k < N; k++) acc_sum = acc_sum + AW'(s3_prod[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        s1_a[k]    <= '0;
        s1_b[k]    <= '0;
        s2_pre[k]  <= '0;
        s3_prod[k] <= '0;
      end
      {s1_c, s2_c, s3_c, s4_c}         <= '0;
      {s1_byp, s2_byp, s3_byp, s4_byp} <= '0;
      s4_acc <= '0;
      dq_q   <= '0;
    end else begin
      if (bus.din_dv) begin
        for (int k = 0; k < N; k++) begin
          s1_a[k] <= tap_a[k];
          s1_b[k] <= tap_b[k];
        end
        s1_c   <= centre;
        s1_byp <= bus.bypass;
      end
      for (int k = 0; k < N; k++) begin
        s2_pre[k]  <= (DW+1)'(s1_a[k]) + (DW+1)'(s1_b[k]);
        s3_prod[k] <= PW'(s2_pre[k]) * PW'(coe_w[k]);
      end
      s2_c   <= s1_c;
      s3_c   <= s2_c;
      s4_c   <= s3_c;
      s2_byp <= s1_byp;
      s3_byp <= s2_byp;
      s4_byp <= s3_byp;
      s4_acc <= acc_sum;
      dq_q   <= dq_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= LAT; i++) side_q[i] <= '0;
    end else begin
      side_q[1] <= side_t'{sync: bus.sync_in, dv: bus.din_dv, chn: bus.din_chn};
      for (int i = 2; i <= LAT; i++) side_q[i] <= side_q[i-1];
    end
  end

`ifdef PRACH_HB_DEC_SAT_EN
  localparam int RW = AW - CW + 1;
  localparam logic signed [RW-1:0] MAXV = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [RW-1:0] res_w;
  logic                 sat_nxt, sat_q, ovf_q;
  logic                 unused_acc;

  assign res_w      = $signed(s4_acc[AW-1:CW-1]);
  assign unused_acc = ^s4_acc[CW-2:0];

  always_comb begin
    dq_nxt  = res_w[DW-1:0];
    sat_nxt = 1'b0;
    if (res_w > MAXV) begin
      dq_nxt  = MAXV[DW-1:0];
      sat_nxt = 1'b1;
    end else if (res_w < MINV) begin
      dq_nxt  = MINV[DW-1:0];
      sat_nxt = 1'b1;
    end
    if (s4_byp) begin
      dq_nxt  = s4_c;
      sat_nxt = 1'b0;
    end
  end

  // A saturating valid output outranks a coincident sync clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sat_q <= sat_nxt;
      ovf_q <= (side_q[LAT].dv & sat_q) | (ovf_q & ~bus.sync_in);
    end
  end

  assign bus.ovf = ovf_q;
`else
  logic unused_acc;
  assign unused_acc = ^{s4_acc[AW-1:CW-1+DW], s4_acc[CW-2:0]};

  always_comb begin
    dq_nxt = s4_acc[CW-1 +: DW];
    if (s4_byp) dq_nxt = s4_c;
  end

  assign bus.ovf = 1'b0;
`endif

  assign bus.dout_dq  = dq_q;
  assign bus.dout_dv  = side_q[LAT].dv;
  assign bus.dout_chn = side_q[LAT].chn;
  assign bus.sync_out = side_q[LAT].sync;
endmodule
